// File: rtl/delay_sweep_pkg.sv
// delay_sweep_pkg: shared types and default sizes for the delay sweep
// sequencer.
//   state_t      - sequencer FSM states
//   sample_t     - one sweep-point record {delay, rdback} at default width
//   DELAY_W_DEF / DWELL_W_DEF / TIMEOUT_DEF - default parameter values
//   max_int      - elaboration-time helper for sizing counters
package delay_sweep_pkg;

    localparam int DELAY_W_DEF = 9;
    localparam int DWELL_W_DEF = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [3:0] {
        IDLE,
        PROG,
        WAIT_PROG,
        DWELL,
        READ,
        WAIT_READ,
        EMIT,
        NEXT,
        FINISH
    } state_t;

    typedef struct packed {
        logic [DELAY_W_DEF-1:0] delay;
        logic [DELAY_W_DEF-1:0] rdback;
    } sample_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/delay_sweep_ctrl_if.sv
// delay_sweep_ctrl_if: change/read/done handshake to one delay-lane DRP
// wrapper.
//   master (sequencer): drives drp_change, drp_read, drp_delay_in;
//                       receives drp_done, drp_delay_out
//   slave  (wrapper)  : the mirror image
interface delay_sweep_ctrl_if
    import delay_sweep_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF
) ();

    logic               drp_change;
    logic               drp_read;
    logic [DELAY_W-1:0] drp_delay_in;
    logic               drp_done;
    logic [DELAY_W-1:0] drp_delay_out;

    modport master (
        output drp_change,
        output drp_read,
        output drp_delay_in,
        input  drp_done,
        input  drp_delay_out
    );

    modport slave (
        input  drp_change,
        input  drp_read,
        input  drp_delay_in,
        output drp_done,
        output drp_delay_out
    );

endinterface

// File: rtl/sweep_timer.sv
// sweep_timer: loadable down-counter that stops at zero.
//   clk, rst_n - clock, asynchronous active-low reset
//   load_i     - load val_i (wins over dec_i)
//   val_i      - load value
//   dec_i      - decrement by one when non-zero
//   zero_o     - counter currently at zero
module sweep_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/delay_sweep_ctrl.sv
// delay_sweep_ctrl: sweeps the tap value of one delay lane across
// [start_val, stop_val] in increments of step. Per point: program the tap,
// wait for done, dwell, read back, wait for done, emit one sample record.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, abort          - sweep control (start pulse, abort level/pulse)
//   start_val, stop_val,
//   step, dwell           - sweep setup, latched at start
//   drp                   - master side of the DRP wrapper handshake
//   sample_valid/_delay/
//   _rdback               - per-point record strobe and payload
//   busy, finished,
//   aborted, error        - status
// Build option SWEEP_TIMEOUT_EN: watchdog of TIMEOUT cycles on each DRP
// transaction; expiry sets error and ends the sweep. Without it error is 0.
module delay_sweep_ctrl
    import delay_sweep_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DELAY_W-1:0]  start_val,
    input  logic [DELAY_W-1:0]  stop_val,
    input  logic [DELAY_W-1:0]  step,
    input  logic [DWELL_W-1:0]  dwell,
    delay_sweep_ctrl_if.master  drp,
    output logic                sample_valid,
    output logic [DELAY_W-1:0]  sample_delay,
    output logic [DELAY_W-1:0]  sample_rdback,
    output logic                busy,
    output logic                finished,
    output logic                aborted,
    output logic                error
);

    // One counter serves both dwell and watchdog, so size it for either.
    localparam int TMR_W = max_int(DWELL_W, $clog2(TIMEOUT + 1));

    typedef struct packed {
        logic [DELAY_W-1:0] delay;
        logic [DELAY_W-1:0] rdback;
    } smp_t;

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cur_q, cur_d;
    logic [DELAY_W-1:0] stop_q, stop_d;
    logic [DELAY_W-1:0] step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               abort_q, abort_d;
    logic               aborted_q, aborted_d;
    smp_t               smp_q, smp_d;

    logic               abort_pend;
    logic [DELAY_W:0]   nxt;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;
    logic [TMR_W-1:0]   dwell_ld;

`ifdef SWEEP_TIMEOUT_EN
    // Loaded in PROG/READ; the wait state sees zero on its 63rd cycle for
    // TIMEOUT=64, so FINISH lands exactly TIMEOUT cycles after the pulse.
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT - 2);
    logic error_q, error_d;
`endif

    sweep_timer #(.W(TMR_W)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    // Dwell counts from dwell-1 so DWELL lasts dwell cycles; 0 still takes one.
    assign dwell_ld = (dwell_q == '0) ? '0 : (TMR_W'(dwell_q) - TMR_W'(1));

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        stop_d    = stop_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;
        smp_d     = smp_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
        error_d   = error_q;
`endif
        abort_pend = abort_q | abort;
        nxt        = {1'b0, cur_q} + {1'b0, step_q};

        if ((state_q != IDLE) && (state_q != FINISH) && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d     = start_val;
                    stop_d    = stop_val;
                    step_d    = (step == '0) ? DELAY_W'(1) : step;
                    dwell_d   = dwell;
                    abort_d   = 1'b0;
                    aborted_d = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
                    error_d   = 1'b0;
`endif
                    // Empty range passes through NEXT: its range test
                    // fails immediately, giving finished two cycles after
                    // start with no DRP access.
                    state_d = (start_val > stop_val) ? NEXT : PROG;
                end
            end
            // PROG and READ always enter their wait state even with an abort
            // pending: the wrapper transaction must finish before anything
            // else is issued.
            PROG: begin
`ifdef SWEEP_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
`endif
                state_d = WAIT_PROG;
            end
            WAIT_PROG: begin
`ifdef SWEEP_TIMEOUT_EN
                tmr_dec = 1'b1;
`endif
                if (drp.drp_done) begin
                    if (abort_pend) begin
                        aborted_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = dwell_ld;
                        state_d  = DWELL;
                    end
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (tmr_zero) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
`endif
            end
            DWELL: begin
                if (abort_pend) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (tmr_zero) begin
                    state_d = READ;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            READ: begin
`ifdef SWEEP_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
`endif
                state_d = WAIT_READ;
            end
            WAIT_READ: begin
`ifdef SWEEP_TIMEOUT_EN
                tmr_dec = 1'b1;
`endif
                if (drp.drp_done) begin
                    if (abort_pend) begin
                        aborted_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        // Captured only for emitted points so the sample
                        // outputs change together with the strobe.
                        smp_d.delay  = cur_q;
                        smp_d.rdback = drp.drp_delay_out;
                        state_d      = EMIT;
                    end
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (tmr_zero) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
`endif
            end
            EMIT: begin
                if (abort_pend) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // nxt is one bit wider, so a wrap past the top tap also
                // compares greater than stop.
                if (abort_pend) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (nxt > {1'b0, stop_q}) begin
                    state_d = FINISH;
                end else begin
                    cur_d   = nxt[DELAY_W-1:0];
                    state_d = PROG;
                end
            end
            FINISH: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
            smp_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            stop_q    <= stop_d;
            step_q    <= step_d;
            dwell_q   <= dwell_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
            smp_q     <= smp_d;
        end
    end

`ifdef SWEEP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Outputs decode straight from the state register, so an async reset
    // clears them in the same cycle.
    assign drp.drp_change   = (state_q == PROG);
    assign drp.drp_read     = (state_q == READ);
    assign drp.drp_delay_in = cur_q;
    assign sample_valid     = (state_q == EMIT);
    assign sample_delay     = smp_q.delay;
    assign sample_rdback    = smp_q.rdback;
    assign busy             = (state_q != IDLE);
    assign finished         = (state_q == FINISH);
    assign aborted          = aborted_q;

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// tb_delay_sweep_ctrl: table-driven sweeps against a behavioural DRP
// wrapper, with a scoreboard of expected samples and programmed taps, plus
// hand-written abort, timeout (SWEEP_TIMEOUT_EN) and reset sequences.
module tb_delay_sweep_ctrl;
    import delay_sweep_pkg::*;

    localparam int DW = DELAY_W_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start, abort;
    logic [DW-1:0] start_val, stop_val, step;
    logic [15:0]   dwell;
    logic          sample_valid, busy, finished, aborted, error;
    logic [DW-1:0] sample_delay, sample_rdback;

    always #5 clk = ~clk;

    delay_sweep_ctrl_if #(.DELAY_W(DW)) dif ();

    delay_sweep_ctrl #(.DELAY_W(DW), .DWELL_W(16), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .start_val     (start_val),
        .stop_val      (stop_val),
        .step          (step),
        .dwell         (dwell),
        .drp           (dif),
        .sample_valid  (sample_valid),
        .sample_delay  (sample_delay),
        .sample_rdback (sample_rdback),
        .busy          (busy),
        .finished      (finished),
        .aborted       (aborted),
        .error         (error)
    );

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural wrapper: done w_lat cycles after change/read, readback
    // equals the programmed tap. Counts protocol violations.
    int            w_lat = 20;
    bit            w_hang = 1'b0;
    int            viol = 0;
    logic          w_busy;
    int            w_cnt;
    logic [DW-1:0] w_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_busy            <= 1'b0;
            w_cnt             <= 0;
            w_val             <= '0;
            dif.drp_done      <= 1'b0;
            dif.drp_delay_out <= '0;
        end else begin
            dif.drp_done <= 1'b0;
            if (dif.drp_change || dif.drp_read) begin
                if (w_busy) viol <= viol + 1;
                w_busy <= 1'b1;
                w_cnt  <= w_lat;
                if (dif.drp_change) w_val <= dif.drp_delay_in;
            end else if (w_busy) begin
                if (dif.drp_delay_in != w_val) viol <= viol + 1;
                if (!w_hang) begin
                    if (w_cnt <= 1) begin
                        dif.drp_done      <= 1'b1;
                        dif.drp_delay_out <= w_val;
                        w_busy            <= 1'b0;
                    end else begin
                        w_cnt <= w_cnt - 1;
                    end
                end
            end
        end
    end

    // Scoreboard and event monitor
    sample_t sb_q[$];
    int      prog_q[$];
    int      n_chg = 0, n_rd = 0, n_smp = 0;
    int      first_chg = -1, sv_cyc = -1, done_cyc = -1;
    bit      arm_first = 1'b0, gap_pend = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dif.drp_change) begin
                    n_chg++;
                    if (prog_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL prog_unexpected: got tap %0d, expected none", dif.drp_delay_in);
                    end else begin
                        int p;
                        p = prog_q.pop_front();
                        chk("prog_val", int'(dif.drp_delay_in), p);
                    end
                    if (arm_first) begin
                        first_chg = cyc;
                        arm_first = 1'b0;
                        chk("busy_at_first_change", int'(busy), 1);
                    end
                    if (gap_pend) begin
                        chk("sv_to_change", cyc - sv_cyc, 2);
                        gap_pend = 1'b0;
                    end
                end
                if (dif.drp_read) n_rd++;
                if (dif.drp_done) done_cyc = cyc;
                if (sample_valid) begin
                    n_smp++;
                    chk("done_to_sv", cyc - done_cyc, 1);
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sample_unexpected: got delay %0d, expected none", sample_delay);
                    end else begin
                        sample_t e;
                        e = sb_q.pop_front();
                        chk("sample_delay", int'(sample_delay), int'(e.delay));
                        chk("sample_rdback", int'(sample_rdback), int'(e.rdback));
                    end
                    sv_cyc   = cyc;
                    gap_pend = 1'b1;
                end
            end
        end
    end

    // Reference model of the visited taps
    task automatic model_push(input int sv, input int ev, input int st);
        int v, s;
        sample_t r;
        s = (st == 0) ? 1 : st;
        v = sv;
        while (v <= ev) begin
            r.delay  = DW'(v);
            r.rdback = DW'(v);
            sb_q.push_back(r);
            prog_q.push_back(v);
            v += s;
        end
    endtask

    task automatic pulse_start(input int sv, input int ev, input int st, input int dw,
                               output int s_cyc);
        @(posedge clk); #1;
        start_val = DW'(sv);
        stop_val  = DW'(ev);
        step      = DW'(st);
        dwell     = 16'(dw);
        start     = 1'b1;
        s_cyc     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_fin(input int budget, output int f_cyc);
        f_cyc = -1;
        for (int i = 0; i < budget && f_cyc < 0; i++) begin
            @(negedge clk);
            if (finished) f_cyc = cyc;
        end
        if (f_cyc < 0) begin
            total++; bad++;
            $display("FAIL finish_timeout: no finished within %0d cycles", budget);
        end
    endtask

    typedef struct {
        int sv;
        int ev;
        int st;
        int dw;
        int lat;
        int exp_n;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int s_cyc, f_cyc, b_smp, b_chg;
        w_lat     = v.lat;
        gap_pend  = 1'b0;
        arm_first = (v.exp_n > 0);
        b_smp     = n_smp;
        b_chg     = n_chg;
        model_push(v.sv, v.ev, v.st);
        pulse_start(v.sv, v.ev, v.st, v.dw, s_cyc);
        wait_fin(3000, f_cyc);
        chk("n_samples", n_smp - b_smp, v.exp_n);
        chk("n_changes", n_chg - b_chg, v.exp_n);
        if (f_cyc >= 0) begin
            if (v.exp_n == 0) begin
                chk("empty_start_to_fin", f_cyc - s_cyc, 2);
            end else begin
                chk("start_to_change", first_chg - s_cyc, 1);
                chk("sv_to_fin", f_cyc - sv_cyc, 2);
            end
        end
        chk("sb_left", sb_q.size(), 0);
        chk("prog_left", prog_q.size(), 0);
        chk("aborted_normal", int'(aborted), 0);
        chk("error_normal", int'(error), 0);
        @(negedge clk);
        chk("busy_after_fin", int'(busy), 0);
        chk("finished_one_cycle", int'(finished), 0);
    endtask

    vec_t tbl[6];

    initial begin
        int  s_cyc, f_cyc, b_smp, b_rd;
        bit  found;
        sample_t r;

        tbl[0] = '{10, 40, 10, 4, 20, 4};
        tbl[1] = '{500, 511, 8, 0, 20, 2};
        tbl[2] = '{50, 20, 5, 2, 20, 0};
        tbl[3] = '{7, 7, 0, 3, 20, 1};
        tbl[4] = '{511, 511, 1, 1, 5, 1};
        tbl[5] = '{0, 511, 200, 0, 1, 3};

        start = 1'b0; abort = 1'b0;
        start_val = '0; stop_val = '0; step = '0; dwell = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_change", int'(dif.drp_change), 0);
        chk("rst_read", int'(dif.drp_read), 0);
        chk("rst_delay_in", int'(dif.drp_delay_in), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_error", int'(error), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Abort during WAIT_READ of the second point
        w_lat = 20; gap_pend = 1'b0; arm_first = 1'b0;
        b_smp = n_smp; b_rd = n_rd;
        r.delay = '0; r.rdback = '0;
        sb_q.push_back(r);
        prog_q.push_back(0);
        prog_q.push_back(30);
        pulse_start(0, 90, 30, 2, s_cyc);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (n_rd - b_rd >= 2) found = 1'b1;
        end
        chk("abort_reached_read2", int'(found), 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_fin(200, f_cyc);
        if (f_cyc >= 0) chk("abort_done_to_fin", f_cyc - done_cyc, 1);
        chk("abort_samples", n_smp - b_smp, 1);
        chk("abort_aborted", int'(aborted), 1);
        chk("abort_prog_left", prog_q.size(), 0);
        @(negedge clk);
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_sticky", int'(aborted), 1);
        // Next start clears aborted (checked inside run_vec)
        run_vec(tbl[3]);

`ifdef SWEEP_TIMEOUT_EN
        // Wrapper never answers
        w_hang = 1'b1; gap_pend = 1'b0; arm_first = 1'b1; b_smp = n_smp;
        prog_q.push_back(3);
        pulse_start(3, 3, 1, 0, s_cyc);
        wait_fin(300, f_cyc);
        if (f_cyc >= 0) chk("timeout_change_to_fin", f_cyc - first_chg, 64);
        chk("timeout_error", int'(error), 1);
        chk("timeout_aborted", int'(aborted), 0);
        chk("timeout_samples", n_smp - b_smp, 0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("timeout_err_cleared_by_rst", int'(error), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        w_hang = 1'b0;
`endif

        // Reset in the middle of a sweep
        w_lat = 20; gap_pend = 1'b0; arm_first = 1'b0; b_smp = n_smp;
        model_push(10, 40, 10);
        pulse_start(10, 40, 10, 4, s_cyc);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (n_smp - b_smp >= 1) found = 1'b1;
        end
        chk("midrst_first_sample", int'(found), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_finished", int'(finished), 0);
        chk("midrst_change", int'(dif.drp_change), 0);
        chk("midrst_read", int'(dif.drp_read), 0);
        chk("midrst_delay_in", int'(dif.drp_delay_in), 0);
        chk("midrst_sample_valid", int'(sample_valid), 0);
        chk("midrst_sample_delay", int'(sample_delay), 0);
        chk("midrst_sample_rdback", int'(sample_rdback), 0);
        chk("midrst_aborted", int'(aborted), 0);
        chk("midrst_error", int'(error), 0);
        sb_q.delete();
        prog_q.delete();
        gap_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_after", int'(busy), 0);
        chk("midrst_no_finished", int'(finished), 0);

        chk("protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1);
    end

endmodule
